// File: rtl/hybrid_noc_pkg.sv
// Shared definitions for the hybrid TDM/BE NoC link: parity sizing,
// per-byte parity generation and the BE receive state encoding.
package hybrid_noc_pkg;

   // BE receive length-policing states
   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } be_rx_state_e;

   // Number of parity bits carried on the link for a given flit width
   function automatic int parity_bits(input int flit_w, input int enable_fdm);
      return (enable_fdm != 0) ? flit_w / 8 : 0;
   endfunction

   // Even parity per byte of a 32-bit flit: bit i = XOR of byte i
   function automatic logic [3:0] byte_parity(input logic [31:0] d);
      logic [3:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/hybrid_noc_link_rx_fifo.sv
// Generic first-word-fall-through FIFO with full/empty/count status.
// The head entry is presented on dout whenever the FIFO is non-empty;
// dout reads as zero while empty.
module hybrid_noc_link_rx_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/hybrid_noc_link_rx.sv
// Router-side receiver for one compute-tile link. TDM flits are parity
// checked and forwarded through one register stage without backpressure;
// BE flits are buffered in a FWFT FIFO with packet-length policing.
module hybrid_noc_link_rx
   import hybrid_noc_pkg::*;
#(
   parameter int FLIT_WIDTH       = 32,
   parameter int ENABLE_FDM       = 1,
   parameter int BE_DEPTH         = 4,
   parameter int MAX_BE_PKT_LEN   = 8,
   parameter int FAULTS_PERMANENT = 0,
   localparam int PARITY_BITS = parity_bits(FLIT_WIDTH, ENABLE_FDM),
   localparam int LINK_WIDTH  = FLIT_WIDTH + PARITY_BITS
) (
   input  logic                  clk_noc,
   input  logic                  rst_noc_n,
   input  logic [LINK_WIDTH-1:0] in_flit,
   input  logic                  in_last,
   input  logic                  tdm_in_valid,
   input  logic                  be_in_valid,
   output logic                  be_in_ready,
   output logic [FLIT_WIDTH-1:0] tdm_out_flit,
   output logic                  tdm_out_last,
   output logic                  tdm_out_valid,
   output logic                  tdm_out_err,
   output logic [FLIT_WIDTH-1:0] be_out_flit,
   output logic                  be_out_last,
   output logic                  be_out_valid,
   input  logic                  be_out_ready,
   output logic                  link_error,
   output logic                  proto_error,
   output logic [15:0]           err_count
);

   localparam int BE_W  = FLIT_WIDTH + 1;
   localparam int CNT_W = $clog2(BE_DEPTH) + 1;
   localparam int LEN_W = $clog2(MAX_BE_PKT_LEN + 1);

   logic [FLIT_WIDTH-1:0] tdm_out_flit_q, tdm_out_flit_d;
   logic                  tdm_out_last_q, tdm_out_last_d;
   logic                  tdm_out_valid_q, tdm_out_valid_d;
   logic                  tdm_out_err_q, tdm_out_err_d;
   logic                  link_error_q, link_error_d;
   logic                  proto_error_q, proto_error_d;
   logic [15:0]           err_count_q, err_count_d;
   be_rx_state_e          state_q, state_d;
   logic [LEN_W-1:0]      pkt_cnt_q, pkt_cnt_d;

   logic                  parity_bad, tdm_bad;
   logic                  be_push, be_last_in, len_ovf;
   logic                  fifo_full, fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic [BE_W-1:0]       fifo_dout;

   // Parity bits exist only when FDM is enabled; otherwise nothing to check
   if (ENABLE_FDM != 0) begin : g_parity
      assign parity_bad = |(byte_parity(in_flit[FLIT_WIDTH-1:0]) ^ in_flit[LINK_WIDTH-1:FLIT_WIDTH]);
   end else begin : g_no_parity
      assign parity_bad = 1'b0;
   end

   assign tdm_bad     = tdm_in_valid & parity_bad;
   assign be_in_ready = (fifo_count != CNT_W'(BE_DEPTH));
   assign be_push     = be_in_valid & ~fifo_full & ~tdm_in_valid;

   // TDM register, error accounting and BE length policing
   always_comb begin
      tdm_out_flit_d  = tdm_out_flit_q;
      tdm_out_last_d  = tdm_out_last_q;
      tdm_out_valid_d = tdm_in_valid;
      tdm_out_err_d   = tdm_bad;
      err_count_d     = err_count_q;
      state_d         = state_q;
      pkt_cnt_d       = pkt_cnt_q;
      be_last_in      = in_last;
      len_ovf         = 1'b0;

      if (tdm_in_valid) begin
         tdm_out_flit_d = in_flit[FLIT_WIDTH-1:0];
         tdm_out_last_d = in_last;
      end
      if (tdm_bad && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
      link_error_d = (FAULTS_PERMANENT != 0) ? (link_error_q | tdm_bad) : tdm_bad;

      if (be_push) begin
         if (in_last) begin
            state_d   = IDLE;
            pkt_cnt_d = '0;
         end else if (pkt_cnt_q == LEN_W'(MAX_BE_PKT_LEN - 1)) begin
            // Overlong packet: terminate it here so downstream sees a framed packet
            len_ovf    = 1'b1;
            be_last_in = 1'b1;
            state_d    = IDLE;
            pkt_cnt_d  = '0;
         end else begin
            state_d   = BODY;
            pkt_cnt_d = pkt_cnt_q + LEN_W'(1);
         end
      end

      proto_error_d = (tdm_in_valid & be_in_valid) | len_ovf;
   end

   // State register
   always_ff @(posedge clk_noc or negedge rst_noc_n) begin
      if (!rst_noc_n) begin
         tdm_out_flit_q  <= '0;
         tdm_out_last_q  <= 1'b0;
         tdm_out_valid_q <= 1'b0;
         tdm_out_err_q   <= 1'b0;
         link_error_q    <= 1'b0;
         proto_error_q   <= 1'b0;
         err_count_q     <= '0;
         state_q         <= IDLE;
         pkt_cnt_q       <= '0;
      end else begin
         tdm_out_flit_q  <= tdm_out_flit_d;
         tdm_out_last_q  <= tdm_out_last_d;
         tdm_out_valid_q <= tdm_out_valid_d;
         tdm_out_err_q   <= tdm_out_err_d;
         link_error_q    <= link_error_d;
         proto_error_q   <= proto_error_d;
         err_count_q     <= err_count_d;
         state_q         <= state_d;
         pkt_cnt_q       <= pkt_cnt_d;
      end
   end

   hybrid_noc_link_rx_fifo #(
      .WIDTH (BE_W),
      .DEPTH (BE_DEPTH)
   ) u_be_fifo (
      .clk   (clk_noc),
      .rst_n (rst_noc_n),
      .push  (be_push),
      .din   ({be_last_in, in_flit[FLIT_WIDTH-1:0]}),
      .pop   (be_out_ready),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tdm_out_flit  = tdm_out_flit_q;
   assign tdm_out_last  = tdm_out_last_q;
   assign tdm_out_valid = tdm_out_valid_q;
   assign tdm_out_err   = tdm_out_err_q;
   assign link_error    = link_error_q;
   assign proto_error   = proto_error_q;
   assign err_count     = err_count_q;
   assign be_out_flit   = fifo_dout[FLIT_WIDTH-1:0];
   assign be_out_last   = fifo_dout[FLIT_WIDTH];
   assign be_out_valid  = ~fifo_empty;

endmodule

// File: tb/tb_hybrid_noc_link_rx.sv
// Bench for hybrid_noc_link_rx: TDM vector table, BE scoreboard, and
// hand-written sequences for FIFO full, length policing, reset and saturation.
module tb_hybrid_noc_link_rx;

   localparam int FW    = 32;
   localparam int LW    = 36;
   localparam int DEPTH = 4;
   localparam int MAXL  = 8;

   logic          clk_noc = 1'b0;
   logic          rst_noc_n;
   logic [LW-1:0] in_flit;
   logic          in_last, tdm_in_valid, be_in_valid, be_out_ready;

   logic          be_in_ready, tdm_out_last, tdm_out_valid, tdm_out_err;
   logic [FW-1:0] tdm_out_flit, be_out_flit;
   logic          be_out_last, be_out_valid, link_error, proto_error;
   logic [15:0]   err_count;

   logic          u1_be_in_ready, u1_tdm_out_last, u1_tdm_out_valid, u1_tdm_out_err;
   logic [FW-1:0] u1_tdm_out_flit, u1_be_out_flit;
   logic          u1_be_out_last, u1_be_out_valid, u1_link_error, u1_proto_error;
   logic [15:0]   u1_err_count;

   always #5 clk_noc = ~clk_noc;

   hybrid_noc_link_rx #(.FAULTS_PERMANENT(0)) u_dut (
      .clk_noc(clk_noc), .rst_noc_n(rst_noc_n), .in_flit(in_flit), .in_last(in_last),
      .tdm_in_valid(tdm_in_valid), .be_in_valid(be_in_valid), .be_in_ready(be_in_ready),
      .tdm_out_flit(tdm_out_flit), .tdm_out_last(tdm_out_last), .tdm_out_valid(tdm_out_valid),
      .tdm_out_err(tdm_out_err), .be_out_flit(be_out_flit), .be_out_last(be_out_last),
      .be_out_valid(be_out_valid), .be_out_ready(be_out_ready), .link_error(link_error),
      .proto_error(proto_error), .err_count(err_count));

   hybrid_noc_link_rx #(.FAULTS_PERMANENT(1)) u_dut_perm (
      .clk_noc(clk_noc), .rst_noc_n(rst_noc_n), .in_flit(in_flit), .in_last(in_last),
      .tdm_in_valid(tdm_in_valid), .be_in_valid(be_in_valid), .be_in_ready(u1_be_in_ready),
      .tdm_out_flit(u1_tdm_out_flit), .tdm_out_last(u1_tdm_out_last), .tdm_out_valid(u1_tdm_out_valid),
      .tdm_out_err(u1_tdm_out_err), .be_out_flit(u1_be_out_flit), .be_out_last(u1_be_out_last),
      .be_out_valid(u1_be_out_valid), .be_out_ready(be_out_ready), .link_error(u1_link_error),
      .proto_error(u1_proto_error), .err_count(u1_err_count));

   typedef struct {
      logic          tdm_v;
      logic          last;
      logic [LW-1:0] flit;
      logic          exp_err;
   } vec_t;

   vec_t         tv[6];
   logic [32:0]  sbq[$];
   int           n_chk = 0;
   int           n_fail = 0;
   int           mcount = 0;
   int           mlen = 0;
   int           merr = 0;
   bit           mperm = 0;
   bit           last_push = 0;
   int           proto_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] par(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   function automatic logic [LW-1:0] mk(input logic [31:0] d, input logic [3:0] flip);
      return {par(d) ^ flip, d};
   endfunction

   // One clock: model the cycle from current inputs, clock, then compare outputs
   task automatic tick();
      bit         push, pop, ovf, bad;
      logic       ex_last;
      logic [32:0] e;
      chk("be_in_ready", be_in_ready, (mcount < DEPTH));
      chk("be_out_valid", be_out_valid, (mcount != 0));
      pop = (mcount != 0) && be_out_ready;
      if (pop) begin
         if (sbq.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("be_out_flit", be_out_flit, e[31:0]);
            chk("be_out_last", be_out_last, e[32]);
         end
      end
      push = be_in_valid && !tdm_in_valid && (mcount < DEPTH);
      ovf = 0;
      ex_last = in_last;
      if (push) begin
         if (in_last) mlen = 0;
         else if (mlen == MAXL - 1) begin ex_last = 1; ovf = 1; mlen = 0; end
         else mlen++;
         sbq.push_back({ex_last, in_flit[31:0]});
      end
      last_push = push;
      mcount = mcount + int'(push) - int'(pop);
      bad = tdm_in_valid && (in_flit[35:32] != par(in_flit[31:0]));
      if (bad && merr != 65535) merr++;
      if (bad) mperm = 1;
      begin
         logic          exp_tv, exp_tl;
         logic [FW-1:0] exp_tf;
         exp_tv = tdm_in_valid;
         exp_tf = in_flit[31:0];
         exp_tl = in_last;
         @(posedge clk_noc);
         #1;
         chk("tdm_out_valid", tdm_out_valid, exp_tv);
         if (exp_tv) begin
            chk("tdm_out_flit", tdm_out_flit, exp_tf);
            chk("tdm_out_last", tdm_out_last, exp_tl);
         end
      end
      chk("tdm_out_err", tdm_out_err, bad);
      chk("link_error", link_error, bad);
      chk("link_error_perm", u1_link_error, mperm);
      chk("err_count", err_count, merr);
      chk("proto_error", proto_error, ((tdm_in_valid && be_in_valid) || ovf));
      if (proto_error) proto_seen++;
   endtask

   task automatic idle_in();
      tdm_in_valid = 0; be_in_valid = 0; in_last = 0; in_flit = '0;
   endtask

   task automatic model_reset();
      sbq.delete(); mcount = 0; mlen = 0; merr = 0; mperm = 0;
   endtask

   initial begin
      bit accepted;
      rst_noc_n = 0; be_out_ready = 0;
      idle_in();

      // Reset values
      #12;
      chk("rst_tdm_out_valid", tdm_out_valid, 0);
      chk("rst_tdm_out_flit", tdm_out_flit, 0);
      chk("rst_tdm_out_err", tdm_out_err, 0);
      chk("rst_be_out_valid", be_out_valid, 0);
      chk("rst_be_out_flit", be_out_flit, 0);
      chk("rst_be_in_ready", be_in_ready, 1);
      chk("rst_link_error", link_error, 0);
      chk("rst_proto_error", proto_error, 0);
      chk("rst_err_count", err_count, 0);
      #10 rst_noc_n = 1;
      @(posedge clk_noc); #1;

      // TDM vector table
      tv[0] = '{1'b1, 1'b0, mk(32'h11223344, 4'b0000), 1'b0};
      tv[1] = '{1'b1, 1'b1, mk(32'hFF000001, 4'b0000), 1'b0};
      tv[2] = '{1'b0, 1'b0, 36'h0, 1'b0};
      tv[3] = '{1'b1, 1'b1, mk(32'h000000FF, 4'b0001), 1'b1};
      tv[4] = '{1'b0, 1'b0, 36'h0, 1'b0};
      tv[5] = '{1'b1, 1'b0, mk(32'hA5A50F0F, 4'b1000), 1'b1};
      chk("parity_0x11223344", mk(32'h11223344, 4'b0000) >> 32, 4'b0000);
      for (int i = 0; i < 6; i++) begin
         tdm_in_valid = tv[i].tdm_v; be_in_valid = 0;
         in_last = tv[i].last; in_flit = tv[i].flit;
         tick();
         chk("tv_err", tdm_out_err, tv[i].exp_err);
      end
      idle_in();
      tick();
      chk("err_count_after_table", err_count, 2);
      chk("perm_link_error_held", u1_link_error, 1);

      // BE fill with downstream stalled
      for (int i = 1; i <= 4; i++) begin
         be_in_valid = 1; in_last = 0; in_flit = {4'h0, 32'hB0000000 + i};
         tick();
      end
      chk("ready_when_full", be_in_ready, 0);
      in_flit = {4'h0, 32'hB0000005}; in_last = 1;
      tick(); tick();
      be_out_ready = 1;
      accepted = 0;
      for (int k = 0; k < 20 && !accepted; k++) begin
         tick();
         accepted = last_push;
      end
      chk("fill_fifth_accepted", accepted, 1);
      idle_in();
      repeat (8) tick();
      chk("fill_drained", sbq.size(), 0);

      // Overlong BE packet
      proto_seen = 0;
      for (int i = 1; i <= 10; i++) begin
         be_in_valid = 1; in_last = (i == 10); in_flit = {4'h0, 32'hC0000000 + i};
         tick();
      end
      idle_in();
      repeat (4) tick();
      chk("overlong_proto_pulses", proto_seen, 1);
      chk("overlong_drained", sbq.size(), 0);

      // Both valids high
      tdm_in_valid = 1; be_in_valid = 1; in_last = 0; in_flit = mk(32'hDEADBEEF, 4'b0000);
      tick();
      idle_in();
      repeat (3) tick();
      chk("both_no_fifo_entry", be_out_valid, 0);

      // Reset mid-packet
      be_out_ready = 0;
      for (int i = 1; i <= 3; i++) begin
         be_in_valid = 1; in_last = 0; in_flit = {4'h0, 32'hD0000000 + i};
         tick();
      end
      idle_in();
      #2 rst_noc_n = 0;
      #1;
      chk("async_rst_be_valid", be_out_valid, 0);
      chk("async_rst_ready", be_in_ready, 1);
      chk("async_rst_perm_link", u1_link_error, 0);
      chk("async_rst_err_count", err_count, 0);
      model_reset();
      #4 rst_noc_n = 1;
      @(posedge clk_noc); #1;
      be_out_ready = 1;
      proto_seen = 0;
      for (int i = 1; i <= MAXL; i++) begin
         be_in_valid = 1; in_last = (i == MAXL); in_flit = {4'h0, 32'hE0000000 + i};
         tick();
      end
      idle_in();
      repeat (4) tick();
      chk("post_rst_no_proto", proto_seen, 0);

      // err_count saturation
      tdm_in_valid = 1; in_flit = mk(32'h00000001, 4'b0001);
      repeat (65535) @(posedge clk_noc);
      #1;
      merr = 65535; mperm = 1;
      chk("err_count_65535", err_count, 16'hFFFF);
      chk("perm_err_count_65535", u1_err_count, 16'hFFFF);
      tick();
      chk("err_count_saturated", err_count, 16'hFFFF);
      idle_in();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
